// File: rtl/cart_rom_responder_if.sv
// Cartridge ROM bus (multiplexed address, latch strobe, data) plus the streaming RAM load port.
// master = console/host side, slave = cart_rom_responder.
interface cart_rom_responder_if;
    logic [7:0]  bus_addr_in;
    logic        bus_latcher_in;
    logic [7:0]  bus_data_out;
    logic        load_en_in;
    logic        load_valid_in;
    logic [15:0] load_addr_in;
    logic [7:0]  load_data_in;
    logic        load_ready_out;

    modport master (
        output bus_addr_in, bus_latcher_in, load_en_in, load_valid_in, load_addr_in,
               load_data_in,
        input  bus_data_out, load_ready_out
    );

    modport slave (
        input  bus_addr_in, bus_latcher_in, load_en_in, load_valid_in, load_addr_in,
               load_data_in,
        output bus_data_out, load_ready_out
    );
endinterface

// File: rtl/cart_rom_responder.sv
// Emulates an external latch + ROM board on the cartridge bus, backed by a loadable block RAM.
// Optional feature macro: CART_ROM_RESP_CHECKSUM_EN (checksum of accepted load bytes).
module cart_rom_responder #(
    parameter int unsigned PERIOD_NS       = 10,
    parameter int unsigned TOTAL_ADDRESSES = 65536,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    cart_rom_responder_if.slave  bus,
    output logic [15:0]          full_addr_out,
    output logic                 oob_out,
    output logic [15:0]          read_count_out,
    output logic [7:0]           drop_count_out,
    output logic [7:0]           checksum_out
);

    localparam int unsigned LatencyCycles = SYNC_STAGES + 3;
    localparam int unsigned AddrWidth     = (TOTAL_ADDRESSES > 1) ? $clog2(TOTAL_ADDRESSES) : 1;
    localparam logic [16:0] Depth         = 17'(TOTAL_ADDRESSES);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TOTAL_ADDRESSES < 1 || TOTAL_ADDRESSES > 65536) begin : g_bad_depth
        $error("TOTAL_ADDRESSES must be in 1..65536");
    end
    if (LatencyCycles * PERIOD_NS > 250) begin : g_bad_latency
        $error("pin-to-data latency exceeds 250 ns");
    end

    typedef enum logic [0:0] {StServe, StLoad} state_e;

    state_e state_q;
    logic   load_ready_q;
    logic [7:0] drop_count_q;

    logic [SYNC_STAGES-1:0][7:0] addr_sync_q;
    logic [SYNC_STAGES-1:0]      latch_sync_q;
    logic [7:0]                  addr_s;
    logic                        latch_s;

    logic [7:0]  hi_q;
    logic [15:0] full_addr_q;
    logic [15:0] full_addr_prev_q;
    logic        latch_dly_q;
    logic [15:0] read_count_q;

    logic [AddrWidth-1:0] ram_addr_q;
    logic                 oob_s2_q;
    logic                 oob_s3_q;
    logic [7:0]           rdata_q;
    logic [7:0]           mem [TOTAL_ADDRESSES];

    logic wr_fire;
    logic wr_in_range;
    logic wr_accept;
    logic wr_drop;

    // Only the last sync stage is visible to the rest of the design.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            addr_sync_q  <= '0;
            latch_sync_q <= '0;
        end else begin
            addr_sync_q  <= {addr_sync_q[SYNC_STAGES-2:0], bus.bus_addr_in};
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], bus.bus_latcher_in};
        end
    end

    assign addr_s  = addr_sync_q[SYNC_STAGES-1];
    assign latch_s = latch_sync_q[SYNC_STAGES-1];

    // latch_dly_q tags each full_addr_q with the strobe level that produced it, so address
    // churn caused by the high-byte latch phase is never counted as a read.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            hi_q             <= '0;
            full_addr_q      <= '0;
            full_addr_prev_q <= '0;
            latch_dly_q      <= 1'b0;
            read_count_q     <= '0;
        end else begin
            if (latch_s) begin
                hi_q <= addr_s;
            end
            full_addr_q      <= {hi_q, addr_s};
            full_addr_prev_q <= full_addr_q;
            latch_dly_q      <= latch_s;
            if (state_q == StServe && !latch_dly_q && full_addr_q != full_addr_prev_q) begin
                read_count_q <= read_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ram_addr_q <= '0;
            oob_s2_q   <= 1'b0;
            oob_s3_q   <= 1'b0;
            rdata_q    <= 8'hFF;
        end else begin
            ram_addr_q <= full_addr_q[AddrWidth-1:0];
            oob_s2_q   <= ({1'b0, full_addr_q} >= Depth);
            oob_s3_q   <= oob_s2_q;
            rdata_q    <= mem[ram_addr_q];
        end
    end

    // A write that coincides with the reset cycle is discarded.
    assign wr_fire     = bus.load_valid_in && load_ready_q && rst_n_in;
    assign wr_in_range = ({1'b0, bus.load_addr_in} < Depth);
    assign wr_accept   = wr_fire && wr_in_range;
    assign wr_drop     = wr_fire && !wr_in_range;

    always_ff @(posedge clk_in) begin
        if (wr_accept) begin
            mem[bus.load_addr_in[AddrWidth-1:0]] <= bus.load_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= StServe;
            load_ready_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= bus.load_en_in ? StLoad : StServe;
            load_ready_q <= bus.load_en_in;
            if (wr_drop && drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

`ifdef CART_ROM_RESP_CHECKSUM_EN
    logic [7:0] checksum_q;
    logic       load_rise;

    assign load_rise = bus.load_en_in && (state_q == StServe);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            checksum_q <= '0;
        end else if (load_rise) begin
            checksum_q <= '0;
        end else if (wr_accept) begin
            checksum_q <= checksum_q + bus.load_data_in;
        end
    end

    assign checksum_out = checksum_q;
`else
    assign checksum_out = 8'h00;
`endif

    assign bus.bus_data_out   = (state_q == StLoad || oob_s3_q) ? 8'hFF : rdata_q;
    assign bus.load_ready_out = load_ready_q;
    assign full_addr_out      = full_addr_q;
    assign oob_out            = oob_s3_q && (state_q == StServe);
    assign read_count_out     = read_count_q;
    assign drop_count_out     = drop_count_q;

endmodule

// File: doc/cart_rom_responder.md
# cart_rom_responder

Responder end of the cartridge ROM bus: emulates the external multiplexed-address ROM board so the console-side ROM loader can be exercised on-FPGA without a physical cartridge. It watches the 8-bit address bus and the high-address latch strobe, reconstructs the 16-bit address exactly as an external transparent latch plus ROM would, and drives the addressed byte back onto the data bus from an internal block RAM. A streaming load port fills that RAM from the host or debug side before the console boots.

## Interface
- PERIOD_NS, 10: clock period in ns, used only for the latency check in Timing.
- TOTAL_ADDRESSES, 65536: number of backed bytes, 1..65536; RAM depth.
- SYNC_STAGES, 2: flop stages on every bus input, minimum 2.

- clk_in  input  1  system clock
- rst_n_in  input  1  synchronous, active-low reset
- bus_addr_in  input  8  multiplexed address from the reader, asynchronous
- bus_latcher_in  input  1  high-byte latch strobe, asynchronous, active-high
- bus_data_out  output  8  byte returned to the reader
- load_en_in  input  1  level: 1 = LOAD mode, 0 = SERVE mode
- load_valid_in  input  1  write request qualifier
- load_addr_in  input  16  write address
- load_data_in  input  8  write data
- load_ready_out  output  1  write accepted when high together with load_valid_in
- full_addr_out  output  16  currently reconstructed address {hi, lo}
- oob_out  output  1  high while full_addr_out ≥ TOTAL_ADDRESSES (SERVE only)
- read_count_out  output  16  number of distinct addresses served, wraps mod 2^16
- drop_count_out  output  8  load writes dropped as out of range, saturates at 255
- checksum_out  output  8  see Configuration

## Operation
- Input sync: bus_addr_in and bus_latcher_in each pass through SYNC_STAGES flops (addr_s, latch_s); no other logic reads the raw pins.
- High-byte latch: transparent-latch emulation. While latch_s = 1, hi_reg <= addr_s every cycle; while latch_s = 0, hi_reg holds. The value present on the last cycle with latch_s = 1 is the stored high byte.
- Low byte: lo = addr_s, unlatched. full_addr = {hi_reg, addr_s}, registered into full_addr_out.
- Read pipeline: full_addr_out → RAM address register → RAM output register → bus_data_out mux. Runs every cycle in SERVE; no request handshake.
- Out of range: full_addr_out ≥ TOTAL_ADDRESSES → bus_data_out = 8'hFF and oob_out = 1, aligned with the same pipeline stage as a valid byte.
- read_count_out increments by 1 on each cycle where full_addr_out differs from its previous value while latch_s = 0 and mode is SERVE; changes during latch-high are not counted.
- States: SERVE and LOAD, driven directly by load_en_in (registered one cycle).
  - SERVE: load_ready_out = 0; load writes ignored.
  - LOAD: load_ready_out = 1; bus_data_out = 8'hFF; oob_out = 0; read_count_out holds.
  - Write fires on load_valid_in & load_ready_out. load_addr_in < TOTAL_ADDRESSES writes RAM; otherwise dropped and drop_count_out increments (saturating).
- RAM contents are never cleared by reset; only registers reset.

## Timing
- Reset values: bus_data_out 8'hFF, load_ready_out 0, full_addr_out 0, oob_out 0, read_count_out 0, drop_count_out 0, checksum_out 0; hi_reg 0; state SERVE; all sync flops 0.
- Latency pin-to-data: bus_addr_in change → bus_data_out valid after exactly SYNC_STAGES + 3 cycles (sync, full_addr_out, RAM addr reg, RAM out reg). Must be ≤ 250 ns / PERIOD_NS; with defaults 5 cycles = 50 ns.
- Mode switch: load_ready_out and bus_data_out = 8'hFF take effect 1 cycle after load_en_in rises; SERVE data valid again SYNC_STAGES + 3 cycles after it falls.
- Load write to same address then read in SERVE: new data returned; write-during-read ordering within LOAD is irrelevant since reads are masked.
- Reset mid-load: any write coinciding with the reset cycle is dropped; previously written RAM bytes persist.
- Simultaneous latch fall and addr change at the pins: hi_reg holds the last value seen with latch_s = 1; bench must not rely on sub-cycle ordering.

## Configuration
- CART_ROM_RESP_CHECKSUM_EN defined: checksum_out = 8-bit wrapping sum of every load_data_in accepted into RAM (dropped writes excluded); cleared by reset and on each rising edge of load_en_in.
- Undefined: checksum logic absent; checksum_out tied to 8'h00.

## Test plan
- Load 0x01A5=0x5A; SERVE; drive addr 0x01, pulse latcher 25 cycles, drop, drive 0xA5 → bus_data_out 0x5A by 5 cycles after the 0xA5 edge, full_addr_out 0x01A5, read_count_out 1.
- TOTAL_ADDRESSES=256; read hi 0x01, lo 0x00 → bus_data_out 0xFF, oob_out 1; then hi 0x00 lo 0x10 → stored byte, oob_out 0.
- Latcher held high while addr goes 0x10 → 0x20, then latcher drops and addr → 0x33 → full_addr_out 0x2033.
- LOAD: bus_data_out 0xFF, load_ready_out 1; write addr 0x0100 with TOTAL_ADDRESSES=256 → drop_count_out 1, RAM unchanged.
- Reset asserted mid-LOAD after writing 0x0005=0x77 → all outputs at reset values next cycle; later SERVE read of 0x0005 returns 0x77.
- With CART_ROM_RESP_CHECKSUM_EN: writes 0x80, 0x90 → checksum_out 0x10; without macro → 0x00.
